pipelined_execution_unit: RTL and testbench

Parametrised successor to the single-cycle execution unit. It accepts one instruction per cycle over a valid/ready handshake, executes it against local A, B and accumulator (ACC) registers, and publishes ACC to a registered output port. New relative to the previous generation:
- width-generic datapath;
- multi-cycle iterative multiply with back-pressure;
- carry and zero flags;
- program-counter tag captured with each output;
- illegal-opcode reporting.

---
 rtl/pipelined_execution_unit.sv | 158 +++++++++++++++
 tb/tb_pipelined_execution_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_execution_unit.sv
// Accumulator-based execution unit. Single-cycle ALU ops, plus an iterative
// shift-add multiply that stalls the valid/ready handshake for W cycles.
module pipelined_execution_unit #(
    parameter int INPUT_DATA_WIDTH  = 4,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int PC_WIDTH          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   opcode,
    input  logic [OUTPUT_DATA_WIDTH-1:0] operand,
    input  logic [PC_WIDTH-1:0]          pc,
    output logic [OUTPUT_DATA_WIDTH-1:0] cpu_out,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic                         out_valid,
    output logic [OUTPUT_DATA_WIDTH-1:0] acc,
    output logic                         zero_flag,
    output logic                         carry_flag,
    output logic                         busy,
    output logic                         illegal
);

    localparam int W     = INPUT_DATA_WIDTH;
    localparam int DW    = OUTPUT_DATA_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_LDO = 4'h3,
        OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR  = 4'h8, OP_INV = 4'h9, OP_CLR = 4'hA, OP_ACCA = 4'hB,
        OP_MUL  = 4'hC, OP_SNZA = 4'hD, OP_LSH = 4'hE, OP_RSH = 4'hF
    } op_t;

    state_t             state_q;
    logic [W-1:0]       a_q, b_q;
    logic [DW-1:0]      acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [DW-1:0]      cpu_out_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    logic               out_valid_q;
    logic               skip_q;
    logic [DW-1:0]      mcand_q, prod_q, prod_step;
    logic [W-1:0]       mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [DW-1:0]      a_ext, b_ext;
    logic [DW:0]        acca_sum;
    op_t                op;

    assign op       = op_t'(opcode);
    assign a_ext    = {{(DW-W){1'b0}}, a_q};
    assign b_ext    = {{(DW-W){1'b0}}, b_q};
    assign acca_sum = {1'b0, acc_q} + {1'b0, a_ext};

    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Result of every single-cycle op that writes ACC and/or carry.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        acc_d   = acc_q;
        carry_d = carry_q;
        case (op)
            OP_ADD:  begin acc_d = a_ext + b_ext; carry_d = 1'b0;    end
            OP_SUB:  begin acc_d = a_ext - b_ext; carry_d = a_q < b_q; end
            OP_AND:  acc_d = a_ext & b_ext;
            OP_OR:   acc_d = a_ext | b_ext;
            OP_XOR:  acc_d = a_ext ^ b_ext;
            OP_INV:  acc_d = ~acc_q;
            OP_CLR:  begin acc_d = '0; carry_d = 1'b0; end
            OP_ACCA: {carry_d, acc_d} = acca_sum;
            OP_LSH:  acc_d = {acc_q[DW-2:0], 1'b0};
            OP_RSH:  acc_d = {1'b0, acc_q[DW-1:1]};
            default: ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            cpu_out_q   <= '0;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
            skip_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            case (op)
                                OP_LDA:  a_q <= operand[DW-1:W];
                                OP_LDB:  b_q <= operand[W-1:0];
                                OP_LDO: begin
                                    cpu_out_q   <= acc_q;
                                    out_pc_q    <= pc;
                                    out_valid_q <= 1'b1;
                                end
                                OP_SNZA: skip_q <= (a_q != '0);
                                OP_MUL: begin
                                    mcand_q  <= a_ext;
                                    mplier_q <= b_q;
                                    prod_q   <= '0;
                                    cnt_q    <= '0;
                                    state_q  <= ST_MUL;
                                end
                                default: begin
                                    acc_q   <= acc_d;
                                    carry_q <= carry_d;
                                end
                            endcase
                        end
                    end
                end
                ST_MUL: begin
                    prod_q   <= prod_step;
                    mcand_q  <= {mcand_q[DW-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[W-1:1]};
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        acc_q   <= prod_step;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_MUL);
    assign cpu_out    = cpu_out_q;
    assign out_pc     = out_pc_q;
    assign out_valid  = out_valid_q;
    assign acc        = acc_q;
    assign zero_flag  = (acc_q == '0);
    assign carry_flag = carry_q;
    // Every 4-bit encoding is defined, so no accepted opcode can be illegal.
    assign illegal    = 1'b0;

endmodule

// File: tb/tb_pipelined_execution_unit.sv
// Directed bench for pipelined_execution_unit (W=4): LDO results go through
// a scoreboard queue checked by an independent out_valid monitor.
module tb_pipelined_execution_unit;

    localparam int W  = 4;
    localparam int DW = 8;
    localparam int PW = 8;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_LDO = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7,
                           OP_XOR = 4'h8, OP_INV = 4'h9, OP_CLR = 4'hA, OP_ACCA = 4'hB,
                           OP_MUL = 4'hC, OP_SNZA = 4'hD, OP_LSH = 4'hE, OP_RSH = 4'hF;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [DW-1:0] operand;
    logic [PW-1:0] pc;
    logic [DW-1:0] cpu_out;
    logic [PW-1:0] out_pc;
    logic          out_valid;
    logic [DW-1:0] acc;
    logic          zero_flag;
    logic          carry_flag;
    logic          busy;
    logic          illegal;

    pipelined_execution_unit #(
        .INPUT_DATA_WIDTH (W),
        .OUTPUT_DATA_WIDTH(DW),
        .PC_WIDTH         (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand   (operand),
        .pc        (pc),
        .cpu_out   (cpu_out),
        .out_pc    (out_pc),
        .out_valid (out_valid),
        .acc       (acc),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag),
        .busy      (busy),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [PW-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every out_valid cycle must match the oldest pending LDO expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            exp_t e;
            n_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got cpu_out=0x%0h out_pc=0x%0h, expected no out_valid",
                         cpu_out, out_pc);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {24'h0, cpu_out}, {24'h0, e.data});
                check("out_pc", {24'h0, out_pc}, {24'h0, e.pc});
            end
        end
    end

    // Presents one instruction and holds it until accepted; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [DW-1:0] opnd, input logic [PW-1:0] p);
        logic ok;
        int   waited;
        waited   = 0;
        opcode   = op;
        operand  = opnd;
        pc       = p;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic ldo(input logic [PW-1:0] p, input logic [DW-1:0] expected);
        exp_q.push_back({expected, p});
        issue(OP_LDO, '0, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall;
        int busy_n;

        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = OP_NOP;
        operand  = '0;
        pc       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_acc", {24'h0, acc}, 32'h0);
        check("rst_cpu_out", {24'h0, cpu_out}, 32'h0);
        check("rst_out_pc", {24'h0, out_pc}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_carry", {31'h0, carry_flag}, 32'h0);
        check("rst_zero", {31'h0, zero_flag}, 32'h1);
        check("rst_illegal", {31'h0, illegal}, 32'h0);

        // 3 + 5 = 8, then publish with pc 0x10
        issue(OP_LDA, 8'h35, 8'h00);
        issue(OP_LDB, 8'h35, 8'h01);
        issue(OP_ADD, 8'h00, 8'h02);
        check("add_acc", {24'h0, acc}, 32'h08);
        ldo(8'h10, 8'h08);
        check("ldo_valid_hi", {31'h0, out_valid}, 32'h1);
        @(posedge clk);
        #1;
        check("ldo_valid_lo", {31'h0, out_valid}, 32'h0);
        check("add_zero", {31'h0, zero_flag}, 32'h0);
        check("add_carry", {31'h0, carry_flag}, 32'h0);

        // 0xF * 0xF = 0xE1 with an LDO held during the stall
        issue(OP_LDA, 8'hF0, 8'h03);
        issue(OP_LDB, 8'h0F, 8'h04);
        issue(OP_MUL, 8'h00, 8'h05);
        exp_q.push_back({8'hE1, 8'h40});
        opcode   = OP_LDO;
        operand  = '0;
        pc       = 8'h40;
        in_valid = 1'b1;
        stall    = 0;
        busy_n   = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) break;
            stall++;
            if (busy) busy_n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mul_stall_cycles", stall, 4);
        check("mul_busy_cycles", busy_n, 4);
        check("mul_acc", {24'h0, acc}, 32'hE1);

        // CLR, INV, LSH -> 0xFE; + A=3 wraps to 0x01 with carry
        issue(OP_CLR, 8'h00, 8'h06);
        issue(OP_INV, 8'h00, 8'h07);
        issue(OP_LSH, 8'h00, 8'h08);
        check("fe_acc", {24'h0, acc}, 32'hFE);
        check("fe_carry", {31'h0, carry_flag}, 32'h0);
        issue(OP_LDA, 8'h30, 8'h09);
        issue(OP_ACCA, 8'h00, 8'h0A);
        check("acca_acc", {24'h0, acc}, 32'h01);
        check("acca_carry", {31'h0, carry_flag}, 32'h1);
        check("acca_zero", {31'h0, zero_flag}, 32'h0);
        issue(OP_CLR, 8'h00, 8'h0B);
        check("clr_acc", {24'h0, acc}, 32'h00);
        check("clr_zero", {31'h0, zero_flag}, 32'h1);
        check("clr_carry", {31'h0, carry_flag}, 32'h0);

        // Skip behaviour with ACC = 0xFF
        issue(OP_INV, 8'h00, 8'h0C);
        issue(OP_LDA, 8'h10, 8'h0D);
        issue(OP_SNZA, 8'h00, 8'h0E);
        issue(OP_LDO, 8'h00, 8'h20);
        ldo(8'h21, 8'hFF);
        issue(OP_SNZA, 8'h00, 8'h0F);
        issue(OP_SNZA, 8'h00, 8'h11);
        ldo(8'h22, 8'hFF);
        issue(OP_SNZA, 8'h00, 8'h12);
        issue(OP_MUL, 8'h00, 8'h13);
        check("skip_mul_busy", {31'h0, busy}, 32'h0);
        check("skip_mul_ready", {31'h0, in_ready}, 32'h1);
        check("skip_mul_acc", {24'h0, acc}, 32'hFF);
        issue(OP_LDA, 8'h00, 8'h14);
        issue(OP_SNZA, 8'h00, 8'h15);
        ldo(8'h23, 8'hFF);
        @(posedge clk);
        #1;
        check("pulse_count", n_pulses, 5);

        // Reset two cycles into a MUL
        issue(OP_LDA, 8'hF0, 8'h16);
        issue(OP_LDB, 8'h0F, 8'h17);
        issue(OP_MUL, 8'h00, 8'h18);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mulrst_acc", {24'h0, acc}, 32'h0);
        check("mulrst_busy", {31'h0, busy}, 32'h0);
        check("mulrst_ready", {31'h0, in_ready}, 32'h1);
        repeat (8) @(posedge clk);
        #1;
        check("mulrst_acc_later", {24'h0, acc}, 32'h0);

        // SUB with borrow, shifts, INV, then logic ops leave carry alone
        issue(OP_LDA, 8'h25, 8'h19);
        issue(OP_LDB, 8'h25, 8'h1A);
        issue(OP_SUB, 8'h00, 8'h1B);
        check("sub_acc", {24'h0, acc}, 32'hFD);
        check("sub_carry", {31'h0, carry_flag}, 32'h1);
        issue(OP_LSH, 8'h00, 8'h1C);
        check("lsh_acc", {24'h0, acc}, 32'hFA);
        issue(OP_RSH, 8'h00, 8'h1D);
        check("rsh_acc", {24'h0, acc}, 32'h7D);
        issue(OP_INV, 8'h00, 8'h1E);
        check("inv_acc", {24'h0, acc}, 32'h82);
        ldo(8'h30, 8'h82);
        issue(OP_LDA, 8'hC0, 8'h1F);
        issue(OP_LDB, 8'h0A, 8'h24);
        issue(OP_AND, 8'h00, 8'h25);
        check("and_acc", {24'h0, acc}, 32'h08);
        check("and_carry", {31'h0, carry_flag}, 32'h1);
        issue(OP_OR, 8'h00, 8'h26);
        check("or_acc", {24'h0, acc}, 32'h0E);
        issue(OP_XOR, 8'h00, 8'h27);
        check("xor_acc", {24'h0, acc}, 32'h06);
        issue(OP_NOP, 8'h00, 8'h28);
        check("nop_acc", {24'h0, acc}, 32'h06);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
